// File: rtl/trigger_ctrl.sv
// trigger_ctrl -- oscilloscope-style trigger controller.
//
// Watches one selected comparator flag and issues a registered one-cycle
// trigger pulse. After a trigger it waits for the capture buffer to finish,
// optionally waits a programmable holdoff, then re-arms or stops depending
// on the acquisition mode. Auto mode fires a trigger by itself when no
// event arrives within AUTO_PERIOD cycles of arming.
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   mode            : 0 normal, 1 auto, 2 single, 3 stop
//   ch_sel          : selected trigger channel (>= NCH means no event)
//   trig_enable     : per-channel trigger-condition flags
//   holdoff         : holdoff length in cycles (0 = none)
//   arm             : re-arm pulse, only honoured while stopped in single mode
//   capture_done    : acquisition-complete pulse, only honoured while busy
//   trig, trig_auto : one-cycle trigger pulse, and "came from the timeout"
//   armed, stopped  : state flags
//   trig_count      : triggers issued, wraps at 2^16
//   state_dbg       : current FSM state (0 armed, 1 busy, 2 holdoff, 3 stopped)
//
// Handshake note: there is no valid/ready pairing here. trig is a pulse that
// is valid for exactly the one cycle it is high; capture_done and arm are
// single-cycle pulses sampled on the rising clock edge.
module trigger_ctrl #(
  parameter int NCH         = 2,
  parameter int AUTO_PERIOD = 640,
  parameter int CNT_W       = 10,
  parameter int HOLD_W      = 8,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [NCH-1:0]    trig_enable,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              arm,
  input  logic              capture_done,
  output logic              trig,
  output logic              trig_auto,
  output logic              armed,
  output logic              stopped,
  output logic [15:0]       trig_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_BUSY    = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_STOPPED = 2'd3
  } state_e;

  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;
  localparam logic [1:0] MODE_STOP   = 2'd3;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   auto_cnt_q, auto_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               trig_q, trig_d;
  logic               trig_auto_q, trig_auto_d;
  logic [15:0]        trig_count_q, trig_count_d;

  logic               event_hit;
  state_e             post_dest;

  always_comb begin
    // Out-of-range channel selects simply never match any index.
    event_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == CH_W'(i)) event_hit = trig_enable[i];
    end

    // Where to go once a capture (and its holdoff) is complete.
    post_dest = (mode == MODE_SINGLE) ? ST_STOPPED : ST_ARMED;

    state_d     = state_q;
    auto_cnt_d  = auto_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    trig_d      = 1'b0;
    trig_auto_d = 1'b0;

    if (mode == MODE_STOP) begin
      state_d = ST_STOPPED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          // A real event beats a simultaneous timeout.
          if (event_hit) begin
            trig_d  = 1'b1;
            state_d = ST_BUSY;
          end else if (mode == MODE_AUTO) begin
            if (auto_cnt_q == CNT_W'(AUTO_PERIOD - 1)) begin
              trig_d      = 1'b1;
              trig_auto_d = 1'b1;
              state_d     = ST_BUSY;
            end else begin
              auto_cnt_d = auto_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_BUSY: begin
          if (capture_done) begin
            if (holdoff != '0) begin
              // Counting holdoff-1 down to 0 spends exactly holdoff cycles here.
              state_d    = ST_HOLDOFF;
              hold_cnt_d = holdoff - HOLD_W'(1);
            end else begin
              state_d = post_dest;
            end
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt_q == '0) state_d = post_dest;
          else                  hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
        ST_STOPPED: begin
          // Normal/auto re-arm on their own; single needs an explicit arm.
          if (mode != MODE_SINGLE || arm) state_d = ST_ARMED;
        end
        default: state_d = ST_ARMED;
      endcase
    end

    // Keeping the counter at zero outside ARMED means every entry starts fresh.
    if (state_d != ST_ARMED) auto_cnt_d = '0;
    if (state_d != ST_HOLDOFF) hold_cnt_d = '0;

    trig_count_d = trig_count_q + {15'd0, trig_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ARMED;
      auto_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      trig_q       <= 1'b0;
      trig_auto_q  <= 1'b0;
      trig_count_q <= '0;
    end else begin
      state_q      <= state_d;
      auto_cnt_q   <= auto_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      trig_q       <= trig_d;
      trig_auto_q  <= trig_auto_d;
      trig_count_q <= trig_count_d;
    end
  end

  assign trig       = trig_q;
  assign trig_auto  = trig_auto_q;
  assign armed      = (state_q == ST_ARMED);
  assign stopped    = (state_q == ST_STOPPED);
  assign trig_count = trig_count_q;
  assign state_dbg  = state_q;

endmodule
